// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit feeding the core data memory
// Optional build macro: LSU_MISALIGN_CHECK_EN (fault misaligned halfword/word accesses)
module load_store_unit #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  mem_wr,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic        accept;
    logic        illegal;
    logic        out_of_range;
    logic        misaligned;
    logic        fault;
    logic [2:0]  nbytes;
    logic [1:0]  size_code;
    logic [32:0] end_addr;
    logic [31:0] load_ext;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid & req_ready;
    assign mem_rd_addr = req_addr;
    assign mem_wr_addr = req_addr;
    assign mem_wr_data = req_wdata;

    always_comb begin
        nbytes    = 3'd4;
        size_code = 2'd3;
        case (req_funct3[1:0])
            2'b00: begin nbytes = 3'd1; size_code = 2'd1; end
            2'b01: begin nbytes = 3'd2; size_code = 2'd2; end
            default: begin nbytes = 3'd4; size_code = 2'd3; end
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign end_addr     = {1'b0, req_addr} + {30'b0, nbytes};
    assign out_of_range = end_addr > 33'(MEM_SIZE);

    assign illegal = req_store ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                               : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110));

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign fault = illegal | out_of_range | misaligned;

    // Reset gating keeps a write from escaping while the unit is held in reset
    assign mem_wr = (rst_n & accept & req_store & ~fault) ? size_code : 2'd0;

    // Memory already presents the addressed byte in [7:0], so only extension remains
    always_comb begin
        load_ext = mem_rd_data;
        case (funct3_q)
            3'b000: load_ext = {{24{mem_rd_data[7]}},  mem_rd_data[7:0]};
            3'b001: load_ext = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
            3'b100: load_ext = {24'b0, mem_rd_data[7:0]};
            3'b101: load_ext = {16'b0, mem_rd_data[15:0]};
            default: load_ext = mem_rd_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            funct3_q  <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= req_funct3;
                        if (fault || req_store) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= fault;
                        end else begin
                            state <= LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_ext;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench with byte-array reference model for load_store_unit
module tb_load_store_unit;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;
    logic [1:0]  mem_wr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    int checks = 0;
    int failures = 0;

    logic [7:0]  env_mem [0:MEM_SIZE-1];
    logic [7:0]  ref_mem [0:MEM_SIZE-1];
    logic [1:0]  exp_wr_now = 2'd0;
    bit          exp_pending = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] env_rd(input longint a);
        if (a < MEM_SIZE) return env_mem[int'(a)];
        return 8'h00;
    endfunction

    // Attached memory: 1-cycle read latency, data aligned to the sampled byte address
    always @(posedge clk) begin
        longint a;
        longint w;
        a = longint'(mem_rd_addr);
        mem_rd_data <= {env_rd(a + 3), env_rd(a + 2), env_rd(a + 1), env_rd(a)};
        w = longint'(mem_wr_addr);
        for (int i = 0; i < 4; i++) begin
            if ((mem_wr == 2'd3 || (mem_wr == 2'd2 && i < 2) || (mem_wr == 2'd1 && i < 1))
                && (w + i) < MEM_SIZE)
                env_mem[int'(w) + i] <= mem_wr_data[8*i +: 8];
        end
    end

    function automatic int m_nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        bit bad;
        longint ua;
        nb = m_nbytes(f3);
        ua = longint'(a);
        if (st) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
        else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (ua + nb > MEM_SIZE) bad = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
        if (nb > 1 && (ua % nb) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int nb;
        nb = m_nbytes(f3);
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
        if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v -= (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // Per-cycle compare against whatever the driver currently expects
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_wr", {30'b0, mem_wr}, {30'b0, exp_wr_now});
            if (rsp_valid) begin
                chk("rsp_expected", {31'b0, exp_pending}, 32'd1);
                if (exp_pending) begin
                    chk("rsp_rdata", rsp_rdata, exp_rdata);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
                end
            end
        end else begin
            chk("rst_mem_wr", {30'b0, mem_wr}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
    end

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input bit keep_valid,
                          input bit use_lit, input logic [31:0] lit_rdata, input bit lit_err);
        bit f;
        int nb;
        int lat;
        int exp_lat;
        logic [1:0] wcode;
        f = m_fault(st, f3, a);
        nb = m_nbytes(f3);
        wcode = (st && !f) ? ((nb == 1) ? 2'd1 : (nb == 2) ? 2'd2 : 2'd3) : 2'd0;
        exp_lat = (st || f) ? 1 : 2;
        exp_err = f;
        exp_rdata = (!st && !f) ? m_load(f3, a) : 32'h0;

        @(posedge clk); #1;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        exp_wr_now = wcode;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        exp_wr_now = 2'd0;
        exp_pending = 1'b1;
        if (st && !f)
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        if (keep_valid) begin
            req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h55555555;
        end else begin
            req_valid = 1'b0;
        end

        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (use_lit) begin
            chk("lit_rdata", rsp_rdata, lit_rdata);
            chk("lit_err", {31'b0, rsp_err}, {31'b0, lit_err});
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("busy_req_ready", {31'b0, req_ready}, 32'd0);
            chk("held_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_pending = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            env_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);

        // st f3 addr wdata hold keep lit lit_rdata lit_err
        do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 1, 32'h0, 0);
        do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
        do_req(0, 3'b000, 32'h103, 32'h0, 0, 0, 1, 32'hFFFFFFDE, 0);
        do_req(0, 3'b100, 32'h103, 32'h0, 0, 0, 1, 32'h000000DE, 0);
        do_req(0, 3'b001, 32'h100, 32'h0, 0, 0, 1, 32'hFFFFBEEF, 0);
        do_req(0, 3'b101, 32'h100, 32'h0, 0, 0, 1, 32'h0000BEEF, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        do_req(1, 3'b001, 32'h101, 32'h00001234, 0, 0, 1, 32'h0, 1);
        do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
`else
        do_req(1, 3'b001, 32'h101, 32'h00001234, 0, 0, 1, 32'h0, 0);
        do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'hDE1234EF, 0);
`endif
        do_req(0, 3'b010, 32'h101, 32'h0, 0, 0, 0, 32'h0, 0);
        do_req(0, 3'b010, 32'h3FE, 32'h0, 0, 0, 1, 32'h0, 1);
        do_req(1, 3'b000, 32'h3FF, 32'h00000080, 0, 0, 0, 32'h0, 0);
        do_req(0, 3'b000, 32'h3FF, 32'h0, 0, 0, 1, 32'hFFFFFF80, 0);
        do_req(0, 3'b100, 32'h3FF, 32'h0, 0, 0, 1, 32'h00000080, 0);
        do_req(0, 3'b011, 32'h100, 32'h0, 0, 0, 1, 32'h0, 1);
        do_req(0, 3'b110, 32'h100, 32'h0, 0, 0, 1, 32'h0, 1);
        do_req(1, 3'b100, 32'h200, 32'h12345678, 0, 0, 1, 32'h0, 1);
        do_req(1, 3'b011, 32'h200, 32'h12345678, 0, 0, 1, 32'h0, 1);
        do_req(1, 3'b010, 32'h3FC, 32'hA5A50F0F, 0, 0, 0, 32'h0, 0);
        do_req(0, 3'b001, 32'h3FE, 32'h0, 0, 0, 1, 32'hFFFFA5A5, 0);
        do_req(1, 3'b010, 32'h3FD, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 1);
        do_req(0, 3'b000, 32'hFFFFFFFF, 32'h0, 0, 0, 1, 32'h0, 1);
        do_req(0, 3'b001, 32'h3FE, 32'h0, 5, 1, 1, 32'hFFFFA5A5, 0);
        do_req(1, 3'b010, 32'h000, 32'h0, 5, 1, 1, 32'h0, 0);
        do_req(0, 3'b010, 32'h000, 32'h0, 0, 0, 1, 32'h0, 0);

        // Reset while the load is outstanding, with a store presented during reset
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk); #1;
        req_store = 1'b1; req_wdata = 32'h11111111;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_rsp_after", {31'b0, rsp_valid}, 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
`else
        do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'hDE1234EF, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
